// File: rtl/multicycle_controller_pkg.sv
// rtl/multicycle_controller_pkg.sv - shared encodings for the multicycle RV32I controller
package multicycle_controller_pkg;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECUTER = 4'd6,
      EXECUTEI = 4'd7,
      ALUWB    = 4'd8,
      BRANCH   = 4'd9,
      JAL      = 4'd10
   } state_t;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_XOR = 4'b0100;
   localparam logic [3:0] ALU_SLT = 4'b0101;
   localparam logic [3:0] ALU_SLL = 4'b0110;
   localparam logic [3:0] ALU_SRL = 4'b0111;
   localparam logic [3:0] ALU_SRA = 4'b1000;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_READDATA  = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   function automatic logic [1:0] imm_src_for(input logic [6:0] op);
      case (op)
         OP_STORE:  return IMM_S;
         OP_BRANCH: return IMM_B;
         OP_JAL:    return IMM_J;
         default:   return IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - controller <-> datapath signal bundle
interface multicycle_controller_if;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       Zero;
   logic       MemReady;

   logic       PCWrite;
   logic       AdrSrc;
   logic       MemWrite;
   logic       IRWrite;
   logic [1:0] ResultSrc;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ImmSrc;
   logic [3:0] ALUControl;
   logic       RegWrite;
   logic       IllegalOp;
   logic [3:0] State;

   modport master (
      input  op, funct3, funct7b5, Zero, MemReady,
      output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
             ImmSrc, ALUControl, RegWrite, IllegalOp, State
   );

   modport slave (
      output op, funct3, funct7b5, Zero, MemReady,
      input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
             ImmSrc, ALUControl, RegWrite, IllegalOp, State
   );
endinterface

// File: rtl/multicycle_controller_aludec.sv
// rtl/multicycle_controller_aludec.sv - ALU operation decoder shared with the single-cycle core
module aludec
   import multicycle_controller_pkg::*;
(
   input  logic       opb5,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic [1:0] ALUOp,
   output logic [3:0] ALUControl
);

   logic rtype_sub;

   // Only register-register ops with IR[30] set subtract; addi ignores IR[30].
   assign rtype_sub = opb5 & funct7b5;

   always_comb begin
      ALUControl = ALU_ADD;
      case (ALUOp)
         ALUOP_ADD: ALUControl = ALU_ADD;
         ALUOP_SUB: ALUControl = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               3'b000:  ALUControl = rtype_sub ? ALU_SUB : ALU_ADD;
               3'b001:  ALUControl = ALU_SLL;
               3'b010:  ALUControl = ALU_SLT;
               3'b011:  ALUControl = ALU_SLT;
               3'b100:  ALUControl = ALU_XOR;
               3'b101:  ALUControl = funct7b5 ? ALU_SRA : ALU_SRL;
               3'b110:  ALUControl = ALU_OR;
               default: ALUControl = ALU_AND;
            endcase
         end
         default: ALUControl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle RV32I control FSM with memory-handshake stalls
module multicycle_controller
   import multicycle_controller_pkg::*;
#(
   parameter bit MEM_WAIT_EN = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset,
   multicycle_controller_if.master bus
);

   state_t     state;
   state_t     state_next;
   logic       mem_ready;
   logic       branch_taken;
   logic [1:0] alu_op;

   logic       pc_write_c;
   logic       ir_write_c;
   logic       mem_write_c;
   logic       reg_write_c;
   logic       illegal_c;
   logic       adr_src;
   logic [1:0] result_src;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;

   assign mem_ready    = MEM_WAIT_EN ? bus.MemReady : 1'b1;
   assign branch_taken = ((bus.funct3 == 3'b000) &  bus.Zero) |
                         ((bus.funct3 == 3'b001) & ~bus.Zero);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= FETCH;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next  = state;
      pc_write_c  = 1'b0;
      ir_write_c  = 1'b0;
      mem_write_c = 1'b0;
      reg_write_c = 1'b0;
      illegal_c   = 1'b0;
      adr_src     = 1'b0;
      result_src  = RES_ALUOUT;
      alu_src_a   = SRCA_PC;
      alu_src_b   = SRCB_RS2;
      alu_op      = ALUOP_ADD;

      case (state)
         FETCH: begin
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALURESULT;
            ir_write_c = mem_ready;
            pc_write_c = mem_ready;
            state_next = mem_ready ? DECODE : FETCH;
         end
         DECODE: begin
            // ALUOut captures OldPC + imm as the branch/jump target
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            case (bus.op)
               OP_LOAD, OP_STORE: state_next = MEMADR;
               OP_REG:            state_next = EXECUTER;
               OP_IMM:            state_next = EXECUTEI;
               OP_BRANCH:         state_next = BRANCH;
               OP_JAL:            state_next = JAL;
               default: begin
                  illegal_c  = 1'b1;
                  state_next = FETCH;
               end
            endcase
         end
         MEMADR: begin
            alu_src_a  = SRCA_RS1;
            alu_src_b  = SRCB_IMM;
            state_next = bus.op[5] ? MEMWRITE : MEMREAD;
         end
         MEMREAD: begin
            adr_src    = 1'b1;
            state_next = mem_ready ? MEMWB : MEMREAD;
         end
         MEMWB: begin
            result_src  = RES_READDATA;
            reg_write_c = 1'b1;
            state_next  = FETCH;
         end
         MEMWRITE: begin
            adr_src     = 1'b1;
            mem_write_c = 1'b1;
            state_next  = mem_ready ? FETCH : MEMWRITE;
         end
         EXECUTER: begin
            alu_src_a  = SRCA_RS1;
            alu_src_b  = SRCB_RS2;
            alu_op     = ALUOP_FUNCT;
            state_next = ALUWB;
         end
         EXECUTEI: begin
            alu_src_a  = SRCA_RS1;
            alu_src_b  = SRCB_IMM;
            alu_op     = ALUOP_FUNCT;
            state_next = ALUWB;
         end
         ALUWB: begin
            reg_write_c = 1'b1;
            state_next  = FETCH;
         end
         BRANCH: begin
            alu_src_a  = SRCA_RS1;
            alu_src_b  = SRCB_RS2;
            alu_op     = ALUOP_SUB;
            pc_write_c = branch_taken;
            state_next = FETCH;
         end
         JAL: begin
            // PC takes the target from ALUOut while the ALU forms OldPC + 4 for rd
            alu_src_a  = SRCA_OLDPC;
            alu_src_b  = SRCB_FOUR;
            pc_write_c = 1'b1;
            state_next = ALUWB;
         end
         default: state_next = FETCH;
      endcase
   end

   // Strobes are gated by reset so nothing writes while reset is asserted.
   assign bus.PCWrite   = pc_write_c  & ~reset;
   assign bus.IRWrite   = ir_write_c  & ~reset;
   assign bus.MemWrite  = mem_write_c & ~reset;
   assign bus.RegWrite  = reg_write_c & ~reset;
   assign bus.IllegalOp = illegal_c   & ~reset;

   assign bus.AdrSrc    = adr_src;
   assign bus.ResultSrc = result_src;
   assign bus.ALUSrcA   = alu_src_a;
   assign bus.ALUSrcB   = alu_src_b;
   assign bus.ImmSrc    = imm_src_for(bus.op);
   assign bus.State     = state;

   aludec u_aludec (
      .opb5       (bus.op[5]),
      .funct3     (bus.funct3),
      .funct7b5   (bus.funct7b5),
      .ALUOp      (alu_op),
      .ALUControl (bus.ALUControl)
   );

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed vector bench for multicycle_controller
module tb_multicycle_controller;

   localparam logic [6:0] LW  = 7'b0000011;
   localparam logic [6:0] SW  = 7'b0100011;
   localparam logic [6:0] RT  = 7'b0110011;
   localparam logic [6:0] IT  = 7'b0010011;
   localparam logic [6:0] BR  = 7'b1100011;
   localparam logic [6:0] JL  = 7'b1101111;
   localparam logic [6:0] BAD = 7'b0000000;

   typedef struct {
      logic [6:0]  op;
      logic [2:0]  f3;
      logic        f7;
      logic        zero;
      logic        mr;
      logic [21:0] exp;
   } vec_t;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   vec_t vecs[$];

   multicycle_controller_if bus ();

   multicycle_controller #(.MEM_WAIT_EN(1'b1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [21:0] outs();
      return {bus.State, bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite,
              bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc,
              bus.ALUControl, bus.RegWrite, bus.IllegalOp};
   endfunction

   // Expected fields: state pcw adr mw irw rs a b imm alu rw ill
   task automatic add(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                      input logic z, input logic mr, input logic [3:0] st,
                      input logic pcw, input logic adr, input logic mw, input logic irw,
                      input logic [1:0] rs, input logic [1:0] a, input logic [1:0] b,
                      input logic [1:0] imm, input logic [3:0] alu,
                      input logic rw, input logic ill);
      vec_t v;
      v.op = op; v.f3 = f3; v.f7 = f7; v.zero = z; v.mr = mr;
      v.exp = {st, pcw, adr, mw, irw, rs, a, b, imm, alu, rw, ill};
      vecs.push_back(v);
   endtask

   task automatic fd(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                     input logic z, input logic [1:0] imm);
      add(op, f3, f7, z, 1'b1, 4'd0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, imm, 4'b0000, 0, 0);
      add(op, f3, f7, z, 1'b1, 4'd1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 4'b0000, 0, 0);
   endtask

   task automatic rtype(input logic [2:0] f3, input logic f7, input logic [3:0] alu);
      fd(RT, f3, f7, 1'b0, 2'b00);
      add(RT, f3, f7, 1'b0, 1'b1, 4'd6, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, alu, 0, 0);
      add(RT, f3, f7, 1'b0, 1'b1, 4'd8, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 1, 0);
   endtask

   task automatic itype(input logic [2:0] f3, input logic f7, input logic [3:0] alu);
      fd(IT, f3, f7, 1'b0, 2'b00);
      add(IT, f3, f7, 1'b0, 1'b1, 4'd7, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, alu, 0, 0);
      add(IT, f3, f7, 1'b0, 1'b1, 4'd8, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 1, 0);
   endtask

   task automatic branch(input logic [2:0] f3, input logic z, input logic taken);
      fd(BR, f3, 1'b0, z, 2'b10);
      add(BR, f3, 1'b0, z, 1'b1, 4'd9, taken, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 4'b0001, 0, 0);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_state(input logic [3:0] tgt, input string name);
      int n;
      n = 0;
      while (bus.State !== tgt && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      check(name, {28'd0, bus.State}, {28'd0, tgt});
   endtask

   task automatic latency(input logic [6:0] o, input int exp, input string name);
      int n;
      bus.op = o;
      n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (bus.State !== 4'd0 && n < 20);
      check(name, n, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int mw_cnt;
      logic rw_seen;
      logic [3:0] end_state;
      checks = 0;
      errors = 0;

      // lw with one fetch stall and one MEMREAD stall
      add(LW, 3'b010, 0, 0, 1'b0, 4'd0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 4'b0000, 0, 0);
      fd(LW, 3'b010, 1'b0, 1'b0, 2'b00);
      add(LW, 3'b010, 0, 0, 1'b1, 4'd2, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 4'b0000, 0, 0);
      add(LW, 3'b010, 0, 0, 1'b0, 4'd3, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 0, 0);
      add(LW, 3'b010, 0, 0, 1'b1, 4'd3, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 0, 0);
      add(LW, 3'b010, 0, 0, 1'b1, 4'd4, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 4'b0000, 1, 0);
      rtype(3'b000, 1'b0, 4'b0000);
      rtype(3'b000, 1'b1, 4'b0001);
      rtype(3'b100, 1'b0, 4'b0100);
      rtype(3'b101, 1'b0, 4'b0111);
      rtype(3'b111, 1'b0, 4'b0010);
      itype(3'b000, 1'b1, 4'b0000);
      itype(3'b101, 1'b1, 4'b1000);
      branch(3'b000, 1'b1, 1'b1);
      branch(3'b001, 1'b1, 1'b0);
      branch(3'b000, 1'b0, 1'b0);
      fd(JL, 3'b000, 1'b0, 1'b0, 2'b11);
      add(JL, 3'b000, 0, 0, 1'b1, 4'd10, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 4'b0000, 0, 0);
      add(JL, 3'b000, 0, 0, 1'b1, 4'd8, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b11, 4'b0000, 1, 0);
      fd(SW, 3'b010, 1'b0, 1'b0, 2'b01);
      add(SW, 3'b010, 0, 0, 1'b1, 4'd2, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 4'b0000, 0, 0);
      add(SW, 3'b010, 0, 0, 1'b1, 4'd5, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 4'b0000, 0, 0);
      add(BAD, 3'b000, 0, 0, 1'b1, 4'd0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 4'b0000, 0, 0);
      add(BAD, 3'b000, 0, 0, 1'b1, 4'd1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 4'b0000, 0, 1);
      add(BAD, 3'b000, 0, 0, 1'b1, 4'd0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 4'b0000, 0, 0);

      reset = 1'b1;
      bus.op = LW; bus.funct3 = 3'b010; bus.funct7b5 = 1'b0;
      bus.Zero = 1'b0; bus.MemReady = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check("reset_outputs", {10'd0, outs()},
            {10'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 4'b0000, 1'b0, 1'b0});
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         bus.op = vecs[i].op; bus.funct3 = vecs[i].f3; bus.funct7b5 = vecs[i].f7;
         bus.Zero = vecs[i].zero; bus.MemReady = vecs[i].mr;
         #1;
         checks++;
         if (outs() !== vecs[i].exp) begin
            errors++;
            $display("FAIL vec%0d: got %h expected %h", i, outs(), vecs[i].exp);
         end
         @(negedge clk);
      end

      // Asynchronous reset in the middle of a stalled store
      bus.op = SW; bus.funct3 = 3'b010; bus.MemReady = 1'b1;
      #1;
      wait_state(4'd5, "reach_memwrite");
      bus.MemReady = 1'b0;
      #1;
      check("memwrite_before_reset", {31'd0, bus.MemWrite}, 32'd1);
      #1;
      bus.MemReady = 1'b1;
      reset = 1'b1;
      #1;
      check("memwrite_async_drop", {31'd0, bus.MemWrite}, 32'd0);
      check("state_async_reset", {28'd0, bus.State}, 32'd0);
      check("irwrite_in_reset", {30'd0, bus.IRWrite, bus.PCWrite}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("state_after_release", {28'd0, bus.State}, 32'd0);
      check("irwrite_first_fetch", {31'd0, bus.IRWrite}, 32'd1);

      // Store with two wait cycles in MEMWRITE
      wait_state(4'd5, "sw_reach_memwrite");
      mw_cnt = 0;
      rw_seen = 1'b0;
      end_state = 4'hf;
      for (int k = 0; k < 4; k++) begin
         bus.MemReady = (k >= 2);
         #1;
         if (bus.MemWrite) mw_cnt++;
         if (bus.RegWrite) rw_seen = 1'b1;
         if (k == 3) end_state = bus.State;
         @(negedge clk);
      end
      check("sw_memwrite_cycles", mw_cnt, 3);
      check("sw_end_state", {28'd0, end_state}, 32'd0);
      check("sw_no_regwrite", {31'd0, rw_seen}, 32'd0);

      wait_state(4'd0, "return_to_fetch");
      bus.MemReady = 1'b1;
      bus.funct3 = 3'b000;
      latency(LW, 5, "lw_latency");
      latency(BR, 3, "branch_latency");
      latency(JL, 4, "jal_latency");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM for the multicycle RV32I datapath: one shared ALU, one unified instruction/data memory port, and an instruction register.
- Each instruction is sequenced over 3–5 states. The block drives per-state strobes and mux selects, and stalls on the memory handshake.
- Sits beside the datapath top in place of the single-cycle controller. Uses the same 4-bit ALUControl encoding and Zero flag.

Parameters:
- MEM_WAIT_EN, 1, 1 = honour MemReady; 0 = MemReady treated as constant 1 (zero-wait memory).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high.
- op  input  7  instruction opcode from IR.
- funct3  input  3  IR[14:12].
- funct7b5  input  1  IR[30].
- Zero  input  1  ALU zero flag.
- MemReady  input  1  memory access completes this cycle.
- PCWrite  output  1  PC register enable.
- AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  output  1  memory write strobe.
- IRWrite  output  1  IR and OldPC enable.
- ResultSrc  output  2  00 = ALUOut, 01 = ReadData, 10 = ALUResult.
- ALUSrcA  output  2  00 = PC, 01 = OldPC, 10 = rs1 reg.
- ALUSrcB  output  2  00 = rs2 reg, 01 = ImmExt, 10 = constant 4.
- ImmSrc  output  2  00 = I, 01 = S, 10 = B, 11 = J.
- ALUControl  output  4  ALU operation.
- RegWrite  output  1  register file write enable.
- IllegalOp  output  1  one-cycle pulse on undecodable opcode.
- State  output  4  current state (debug).

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-high and forces State = FETCH.
- While reset is high: PCWrite, IRWrite, MemWrite, RegWrite and IllegalOp are 0. All other outputs take their FETCH values.
- Reset mid-instruction abandons the instruction. No write strobe is issued after reset asserts.
- Default output values: all strobes 0, selects 00, ALUOp 00.
- ImmSrc is purely combinational from op:
  - lw and OP-IMM: 00.
  - sw: 01.
  - branch: 10.
  - jal: 11.
  - others: 00.
- ALUControl derivation (ALUOp is internal):
  - ALUOp 00: ADD.
  - ALUOp 01: SUB.
  - ALUOp 10: decoded from funct3, funct7b5 and op[5]. SUB only when op[5] & funct7b5 and funct3 = 000. SRA when funct3 = 101 & funct7b5.
- States (4-bit encoding, in order): FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BRANCH 9, JAL 10.
- FETCH:
  - AdrSrc = 0, ALUSrcA = 00, ALUSrcB = 10, ALUOp = 00, ResultSrc = 10.
  - IRWrite = PCWrite = MemReady.
  - Stays in FETCH while MemReady = 0; goes to DECODE otherwise.
- DECODE:
  - ALUSrcA = 01, ALUSrcB = 01, ALUOp = 00 (computes branch/jump target into ALUOut).
  - Next state by op:
    - 0000011 or 0100011: MEMADR.
    - 0110011: EXECUTER.
    - 0010011: EXECUTEI.
    - 1100011: BRANCH.
    - 1101111: JAL.
    - anything else: IllegalOp = 1, back to FETCH.
- MEMADR: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 00. Goes to MEMREAD if op[5] = 0, else MEMWRITE.
- MEMREAD: AdrSrc = 1, ResultSrc = 00. Holds until MemReady, then MEMWB.
- MEMWB: ResultSrc = 01, RegWrite = 1, then FETCH.
- MEMWRITE: AdrSrc = 1, ResultSrc = 00, MemWrite = 1 held every cycle until MemReady. FETCH in the cycle after MemReady.
- EXECUTER: ALUSrcA = 10, ALUSrcB = 00, ALUOp = 10, then ALUWB.
- EXECUTEI: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 10, then ALUWB.
- ALUWB: ResultSrc = 00, RegWrite = 1, then FETCH.
- JAL: ALUSrcA = 01, ALUSrcB = 10, ALUOp = 00, ResultSrc = 00, PCWrite = 1, then ALUWB (writes OldPC+4 to rd).
- BRANCH:
  - ALUSrcA = 10, ALUSrcB = 00, ALUOp = 01, ResultSrc = 00.
  - PCWrite = (funct3 = 000 & Zero) | (funct3 = 001 & ~Zero). Other funct3 values: not taken.
  - Then FETCH.
- Latencies in clk cycles with zero-wait memory: lw 5, sw 4, R/I 4, jal 4, branch 3.
- Each memory wait cycle adds 1.
- MemReady is ignored outside FETCH, MEMREAD and MEMWRITE.

Decomposition:
- Shared package holds:
  - state encoding constants.
  - ALUOp codes.
  - ALUControl codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLL 0110, SRL 0111, SRA 1000.
  - opcode constants.
  - ImmSrc and mux-select codes.
- One sub-module: the existing aludec, instantiated unchanged for ALUControl.
- The FSM, output decode and ImmSrc decode stay in this block.

Test Plan:
- Reset: assert reset mid-MEMWRITE with MemReady = 0 → MemWrite drops to 0 immediately (asynchronous). State = 0 after release; first FETCH asserts IRWrite when MemReady = 1.
- lw (op 0000011), MemReady always 1 → State sequence 0, 1, 2, 3, 4, 0. RegWrite = 1 only in state 4 with ResultSrc = 01.
- sw with MemReady low for 2 cycles in MEMWRITE → MemWrite = 1 for 3 consecutive cycles, then State = 0. RegWrite never asserts.
- beq with Zero = 1, then bne with Zero = 1 → PCWrite = 1 in BRANCH for beq, 0 for bne. ALUControl = 0001 in both.
- R-type sub (funct3 000, funct7b5 1) → ALUControl = 0001 in EXECUTER. Same operands as addi with IR[30] = 1 → 0000 in EXECUTEI.
- Opcode 0000000 → IllegalOp pulses one cycle in DECODE, then State = 0. No RegWrite, MemWrite or PCWrite is issued.
